pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the in-order MIPS core. It generalises the fixed two-source stall logic to any number of stages. It adds a registered exception-flush sequencer that redirects the PC and holds a flush for a configurable number of cycles. Optional saturating performance counters track stall and flush activity. It sits beside the pipeline registers: it takes per-stage stall requests plus an exception request, and drives every stage's stall bit, the flush line and the redirect PC.

## Interface
- NSTAGE, 6, number of pipeline control points; bit 0 = PC, bit k = stage k register.
- PC_W, 32, width of the redirect PC.
- FLUSH_CYC, 1, cycles flush stays high per exception; legal range 1..15.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq  in  NSTAGE  per-stage stall request; bit k=1 means stage k cannot advance; bit 0 is ignored.
- excp_req  in  1  exception/redirect request, single-cycle qualified.
- excp_pc  in  PC_W  handler address, valid with excp_req.
- stall  out  NSTAGE  per-control-point stall, 1 = hold.
- flush  out  1  clear all pipeline registers.
- new_pc  out  PC_W  redirect target, valid while flush=1.
- busy  out  1  1 while the flush sequence is active.
- stall_cnt  out  CNT_W  cycles with stall[0]=1.
- flush_cnt  out  CNT_W  number of accepted exceptions.

## Operation
- Stall priority, combinational:
  - Take k = the highest index in 1..NSTAGE-1 with stallreq[k]=1.
  - stall[k:0] = all ones; stall[NSTAGE-1:k+1] = 0.
  - No request: stall = 0.
  - With NSTAGE=6, req at 4 gives 6'b011111; req at 2 gives 6'b000111; both 2 and 3 give 6'b001111.
- Stall override: stall is forced to 0 while rst=1, while excp_req=1 in RUN, or while the FSM is in FLUSH.
- FSM states are RUN and FLUSH.
  - RUN: if excp_req=1 at a rising edge, latch excp_pc into new_pc, load the counter with FLUSH_CYC-1, and go to FLUSH.
  - FLUSH: flush=1, busy=1, and excp_req is ignored (dropped, not queued). When the counter is 0 at an edge, go to RUN; otherwise decrement.
- flush and busy are Moore outputs of FLUSH. flush is high for exactly FLUSH_CYC cycles per accepted exception.
- new_pc holds its last latched value outside FLUSH.
- stallreq arriving during FLUSH has no effect until the first RUN cycle.

## Timing
- Reset values:
  - state RUN; counter 0.
  - stall=0, flush=0, busy=0, new_pc=0.
  - stall_cnt=0, flush_cnt=0.
- rst is sampled at the clock edge; it overrides everything, including mid-FLUSH. The edge with rst=1 returns the FSM to RUN and drops flush.
- Stall latency: 0 cycles (stallreq to stall is combinational).
- Flush latency: excp_req high in cycle N gives flush=1 and new_pc=excp_pc in cycles N+1..N+FLUSH_CYC. busy is high over the same cycles.
- Back-to-back: an excp_req in the last FLUSH cycle is ignored. An excp_req in the first RUN cycle after FLUSH is accepted.
- Counter width is $clog2(FLUSH_CYC+1) bits.

## Configuration
- PIPE_PERF_EN defined:
  - stall_cnt increments at each edge where stall[0]=1 (post-override).
  - flush_cnt increments on each RUN→FLUSH transition.
  - Both saturate at all ones and clear on rst.
- PIPE_PERF_EN undefined:
  - stall_cnt and flush_cnt are tied to 0 and no counter flops are built.
  - Ports remain present.

## Test plan
- Reset for 2 cycles while stallreq=6'b111110 and excp_req=1 -> stall=0, flush=0, busy=0, new_pc=0 throughout, and counters are 0 after reset.
- NSTAGE=6, stallreq=6'b000100 then 6'b011100 -> stall=6'b000111, then 6'b011111, with no cycle delay.
- FLUSH_CYC=3, excp_req=1 with excp_pc=32'hBFC00380 in cycle 10, stallreq=6'b001000 held -> flush=1, busy=1, new_pc=BFC00380 in cycles 11-13, and stall=0 in cycles 10-13. stall returns to 6'b001111 in cycle 14.
- FLUSH_CYC=2, second excp_req (pc 32'h80000180) during cycle 12 (last FLUSH cycle) -> ignored, new_pc stays BFC00380. Repeating it in cycle 13 -> flush in cycles 14-15 with new_pc=80000180.
- rst asserted in the 2nd cycle of a FLUSH_CYC=4 flush -> flush=0 and busy=0 from the next edge, and a following excp_req is accepted normally.
- PIPE_PERF_EN, CNT_W=4, continuous stallreq[1]=1 for 20 cycles plus 2 exceptions -> stall_cnt saturates at 4'hF and flush_cnt=2. Without the macro, both read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: priority stall mask, registered exception-flush sequencer
// with PC redirect, and optional saturating perf counters (enabled by PIPE_PERF_EN).
module pipe_ctrl #(
   parameter int unsigned NSTAGE    = 6,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned FLUSH_CYC = 1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq,
   input  logic              excp_req,
   input  logic [PC_W-1:0]   excp_pc,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic [PC_W-1:0]   new_pc,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int unsigned CYC_W = $clog2(FLUSH_CYC + 1);

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cnt_q, cnt_d;
   logic [PC_W-1:0]   new_pc_q, new_pc_d;
   logic              flush_q, flush_d;
   logic              busy_q, busy_d;

   logic [NSTAGE-1:0] stall_raw;
   logic              stall_acc;
   logic              stall_kill;
   logic              excp_accept;
   logic              unused_stallreq0;

   assign unused_stallreq0 = stallreq[0];
   assign excp_accept      = (state_q == ST_RUN) && excp_req;

   // Every control point at or below the highest requesting stage holds.
   always_comb begin
      stall_acc = 1'b0;
      stall_raw = '0;
      for (int i = NSTAGE - 1; i >= 1; i--) begin
         stall_acc    = stall_acc | stallreq[i];
         stall_raw[i] = stall_acc;
      end
      stall_raw[0] = stall_acc;
   end

   assign stall_kill = rst || excp_accept || (state_q == ST_FLUSH);
   assign stall      = stall_kill ? '0 : stall_raw;

   // Flush sequencer next-state; requests arriving during FLUSH are dropped.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      new_pc_d = new_pc_q;
      unique case (state_q)
         ST_RUN: begin
            if (excp_req) begin
               state_d  = ST_FLUSH;
               cnt_d    = CYC_W'(FLUSH_CYC - 1);
               new_pc_d = excp_pc;
            end
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - CYC_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
      flush_d = (state_d == ST_FLUSH);
      busy_d  = (state_d == ST_FLUSH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         cnt_q    <= '0;
         new_pc_q <= '0;
         flush_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         new_pc_q <= new_pc_d;
         flush_q  <= flush_d;
         busy_q   <= busy_d;
      end
   end

   assign flush  = flush_q;
   assign busy   = busy_q;
   assign new_pc = new_pc_q;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating activity counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall[0] && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (excp_accept && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: three instances with FLUSH_CYC of 3, 2 and 4
// exercise stall priority, flush timing, back-to-back requests and mid-flush reset.
module tb_pipe_ctrl;

   localparam int unsigned NS = 6;
   localparam int unsigned PW = 32;
   localparam int unsigned CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NS-1:0] stallreq;
   logic [PW-1:0] excp_pc;
   logic          rst_a, rst_b, rst_c;
   logic          req_a, req_b, req_c;

   logic [NS-1:0] stall_a, stall_b, stall_c;
   logic          flush_a, flush_b, flush_c;
   logic          busy_a, busy_b, busy_c;
   logic [PW-1:0] pc_a, pc_b, pc_c;
   logic [CW-1:0] scnt_a, scnt_b, scnt_c;
   logic [CW-1:0] fcnt_a, fcnt_b, fcnt_c;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.NSTAGE(NS), .PC_W(PW), .FLUSH_CYC(3), .CNT_W(CW)) u_a (
      .clk(clk), .rst(rst_a), .stallreq(stallreq), .excp_req(req_a), .excp_pc(excp_pc),
      .stall(stall_a), .flush(flush_a), .new_pc(pc_a), .busy(busy_a),
      .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

   pipe_ctrl #(.NSTAGE(NS), .PC_W(PW), .FLUSH_CYC(2), .CNT_W(CW)) u_b (
      .clk(clk), .rst(rst_b), .stallreq(stallreq), .excp_req(req_b), .excp_pc(excp_pc),
      .stall(stall_b), .flush(flush_b), .new_pc(pc_b), .busy(busy_b),
      .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

   pipe_ctrl #(.NSTAGE(NS), .PC_W(PW), .FLUSH_CYC(4), .CNT_W(CW)) u_c (
      .clk(clk), .rst(rst_c), .stallreq(stallreq), .excp_req(req_c), .excp_pc(excp_pc),
      .stall(stall_c), .flush(flush_c), .new_pc(pc_c), .busy(busy_c),
      .stall_cnt(scnt_c), .flush_cnt(fcnt_c));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
      stallreq = 6'b111110;
      excp_pc  = 32'hDEAD_BEEF;
      #1;
      chk("rst_stall_comb", 64'(stall_a), 64'h0);

      // Two reset cycles with stall and exception requests active.
      for (int n = 0; n < 2; n++) begin
         tick();
         chk("rst_stall_a", 64'(stall_a), 64'h0);
         chk("rst_flush_a", 64'(flush_a), 64'h0);
         chk("rst_busy_a",  64'(busy_a),  64'h0);
         chk("rst_pc_a",    64'(pc_a),    64'h0);
         chk("rst_flush_b", 64'(flush_b), 64'h0);
         chk("rst_flush_c", 64'(flush_c), 64'h0);
      end
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
      stallreq = '0;
      #1;
      chk("cnt_s_a", 64'(scnt_a), 64'h0);
      chk("cnt_f_a", 64'(fcnt_a), 64'h0);
      chk("cnt_s_b", 64'(scnt_b), 64'h0);
      chk("cnt_f_b", 64'(fcnt_b), 64'h0);
      chk("cnt_s_c", 64'(scnt_c), 64'h0);
      chk("cnt_f_c", 64'(fcnt_c), 64'h0);
      chk("idle_stall", 64'(stall_a), 64'h0);

      // Stall priority, zero latency.
      tick();
      stallreq = 6'b000100; #1; chk("prio_2",    64'(stall_a), 64'h07);
      stallreq = 6'b011100; #1; chk("prio_4",    64'(stall_a), 64'h1F);
      stallreq = 6'b001100; #1; chk("prio_23",   64'(stall_a), 64'h0F);
      stallreq = 6'b000001; #1; chk("prio_bit0", 64'(stall_a), 64'h00);
      stallreq = 6'b100000; #1; chk("prio_5",    64'(stall_b), 64'h3F);
      stallreq = 6'b000010; #1; chk("prio_1",    64'(stall_c), 64'h03);

      // FLUSH_CYC=3 exception on instance a while stage 3 requests a stall.
      tick();
      stallreq = 6'b001000;
      req_a = 1'b1; excp_pc = 32'hBFC0_0380; #1;
      chk("ex_a_c10_stall", 64'(stall_a), 64'h0);
      chk("ex_a_c10_flush", 64'(flush_a), 64'h0);
      chk("ex_a_c10_other", 64'(stall_b), 64'h0F);
      for (int n = 1; n <= 3; n++) begin
         tick();
         req_a = 1'b0; #1;
         chk("ex_a_flush", 64'(flush_a), 64'h1);
         chk("ex_a_busy",  64'(busy_a),  64'h1);
         chk("ex_a_pc",    64'(pc_a),    64'hBFC0_0380);
         chk("ex_a_stall", 64'(stall_a), 64'h0);
      end
      tick(); #1;
      chk("ex_a_end_flush", 64'(flush_a), 64'h0);
      chk("ex_a_end_busy",  64'(busy_a),  64'h0);
      chk("ex_a_end_stall", 64'(stall_a), 64'h0F);
      chk("ex_a_end_pc",    64'(pc_a),    64'hBFC0_0380);

      // FLUSH_CYC=2 back-to-back on instance b.
      req_b = 1'b1; excp_pc = 32'hBFC0_0380; #1;
      tick();
      req_b = 1'b0; #1;
      chk("b2b_c11_flush", 64'(flush_b), 64'h1);
      tick();
      req_b = 1'b1; excp_pc = 32'h8000_0180; #1;
      chk("b2b_c12_flush", 64'(flush_b), 64'h1);
      chk("b2b_c12_pc",    64'(pc_b),    64'hBFC0_0380);
      chk("b2b_c12_stall", 64'(stall_b), 64'h0);
      tick(); #1;
      chk("b2b_c13_flush", 64'(flush_b), 64'h0);
      chk("b2b_c13_busy",  64'(busy_b),  64'h0);
      chk("b2b_c13_pc",    64'(pc_b),    64'hBFC0_0380);
      chk("b2b_c13_stall", 64'(stall_b), 64'h0);
      tick();
      req_b = 1'b0; #1;
      chk("b2b_c14_flush", 64'(flush_b), 64'h1);
      chk("b2b_c14_pc",    64'(pc_b),    64'h8000_0180);
      tick(); #1;
      chk("b2b_c15_flush", 64'(flush_b), 64'h1);
      tick(); #1;
      chk("b2b_c16_flush", 64'(flush_b), 64'h0);
      chk("b2b_c16_stall", 64'(stall_b), 64'h0F);

      // FLUSH_CYC=4 reset mid-flush on instance c.
      req_c = 1'b1; excp_pc = 32'hBFC0_0380; #1;
      tick();
      req_c = 1'b0; #1;
      chk("rmf_f1_flush", 64'(flush_c), 64'h1);
      tick();
      rst_c = 1'b1; #1;
      chk("rmf_f2_flush", 64'(flush_c), 64'h1);
      chk("rmf_f2_stall", 64'(stall_c), 64'h0);
      tick();
      rst_c = 1'b0; #1;
      chk("rmf_post_flush", 64'(flush_c), 64'h0);
      chk("rmf_post_busy",  64'(busy_c),  64'h0);
      chk("rmf_post_pc",    64'(pc_c),    64'h0);
      req_c = 1'b1; excp_pc = 32'h8000_0180; #1;
      tick();
      req_c = 1'b0; #1;
      chk("rmf_re_flush", 64'(flush_c), 64'h1);
      chk("rmf_re_pc",    64'(pc_c),    64'h8000_0180);
      tick(); tick(); tick();
      chk("rmf_re_f4", 64'(flush_c), 64'h1);
      tick();
      chk("rmf_re_done", 64'(flush_c), 64'h0);

      // Perf counters on instance a (CNT_W=4).
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0; stallreq = 6'b000010; #1;
      chk("perf_start_stall", 64'(stall_a), 64'h03);
      chk("perf_start_cnt",   64'(scnt_a),  64'h0);
      for (int n = 0; n < 10; n++) tick();
`ifdef PIPE_PERF_EN
      chk("perf_s10", 64'(scnt_a), 64'd10);
`else
      chk("perf_s10", 64'(scnt_a), 64'd0);
`endif
      for (int n = 0; n < 10; n++) tick();
`ifdef PIPE_PERF_EN
      chk("perf_s20_sat", 64'(scnt_a), 64'hF);
`else
      chk("perf_s20_sat", 64'(scnt_a), 64'h0);
`endif
      for (int e = 0; e < 2; e++) begin
         req_a = 1'b1; excp_pc = 32'h8000_0180;
         tick();
         req_a = 1'b0;
         tick(); tick(); tick();
      end
      #1;
      chk("perf_back_run", 64'(flush_a), 64'h0);
`ifdef PIPE_PERF_EN
      chk("perf_s_final", 64'(scnt_a), 64'hF);
      chk("perf_f_final", 64'(fcnt_a), 64'd2);
`else
      chk("perf_s_final", 64'(scnt_a), 64'h0);
      chk("perf_f_final", 64'(fcnt_a), 64'h0);
`endif
      chk("perf_b_f", 64'(fcnt_b), 64'h0 `ifdef PIPE_PERF_EN + 64'd2 `endif);
      chk("perf_c_f", 64'(fcnt_c), 64'h0 `ifdef PIPE_PERF_EN + 64'd1 `endif);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
